// File: rtl/rd_capture_buf.sv
// rtl/rd_capture_buf.sv - read-data capture stage with burst-framing output FIFO
module rd_capture_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          ds,
    input  logic [DW-1:0] mem_data,
    input  logic [3:0]    burst_len,
    output logic          ws,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] L_DEPTH    = (PW + 1)'(DEPTH);
    localparam logic [PW:0] L_DEPTH_M2 = (PW + 1)'(DEPTH - 2);
    localparam logic [PW:0] L_ONE      = (PW + 1)'(1);
    localparam logic [PW:0] L_TWO      = (PW + 1)'(2);

    // FIFO storage: each entry is {last, data}
    logic [DW:0]    r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic           r_stg_vld;
    logic [DW-1:0]  r_stg_data;
    logic [3:0]     r_beat_cnt;
    logic [3:0]     r_len_q;
    logic           r_ovf;

    logic [PW-1:0]  w_count;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic [PW:0]    w_free_pop;
    logic [PW:0]    w_occ;
    logic [DW:0]    w_head;
    logic           w_req0;
    logic           w_req1;
    logic [DW:0]    w_word0;
    logic [DW:0]    w_word1;
    logic           w_acc0;
    logic           w_acc1;
    logic           w_drop;
    logic           w_ds_err;
    logic           w_stg_vld_nxt;
    logic [DW-1:0]  w_stg_data_nxt;
    logic [PW-1:0]  w_wptr_p1;
    logic [PW-1:0]  w_push_n;

    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_pop      = out_valid && out_ready;
    assign w_free_pop = L_DEPTH - {1'b0, w_count} + {{PW{1'b0}}, w_pop};
    assign w_occ      = {1'b0, w_count} + {{PW{1'b0}}, r_stg_vld};
    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign w_wptr_p1  = r_wptr + 1'b1;

    // Read side is combinational from the head entry; outputs forced to zero while empty or in reset
    always_comb begin
        out_valid = rst && !w_empty;
        out_data  = out_valid ? w_head[DW-1:0] : '0;
        out_last  = out_valid ? w_head[DW] : 1'b0;
        ws        = rst && (r_beat_cnt < r_len_q) && (w_occ <= L_DEPTH_M2);
        ovf       = r_ovf;
    end

    // Decide which words are offered to the FIFO this cycle and the next stage contents
    always_comb begin
        w_req0         = 1'b0;
        w_req1         = 1'b0;
        w_word0        = '0;
        w_word1        = '0;
        w_ds_err       = 1'b0;
        w_stg_vld_nxt  = r_stg_vld;
        w_stg_data_nxt = r_stg_data;
        if (rd) begin
            w_stg_data_nxt = mem_data;
            w_stg_vld_nxt  = !ds;
            if (r_stg_vld) begin
                w_req0  = 1'b1;
                w_word0 = {1'b0, r_stg_data};
                if (ds) begin
                    w_req1  = 1'b1;
                    w_word1 = {1'b1, mem_data};
                end
            end else if (ds) begin
                w_req0  = 1'b1;
                w_word0 = {1'b1, mem_data};
            end
        end else if (ds) begin
            w_stg_vld_nxt = 1'b0;
            if (r_stg_vld) begin
                w_req0  = 1'b1;
                w_word0 = {1'b1, r_stg_data};
            end else begin
                w_ds_err = 1'b1;
            end
        end
    end

    // Capacity check: a second word needs two free slots after the same-cycle pop
    always_comb begin
        w_acc0   = w_req0 && (!w_full || w_pop) && (w_free_pop >= L_ONE);
        w_acc1   = w_req1 && (w_free_pop >= L_TWO);
        w_drop   = (w_req0 && !w_acc0) || (w_req1 && !w_acc1);
        w_push_n = PW'(w_acc0) + PW'(w_acc1);
    end

    // FIFO entry writes; storage needs no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_acc0) begin
            r_mem[r_wptr[AW-1:0]] <= w_word0;
        end
        if (w_acc1) begin
            r_mem[w_wptr_p1[AW-1:0]] <= w_word1;
        end
    end

    // Pointers, stage register and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_stg_vld  <= 1'b0;
            r_stg_data <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_wptr     <= r_wptr + w_push_n;
            r_rptr     <= r_rptr + PW'(w_pop);
            r_stg_vld  <= w_stg_vld_nxt;
            r_stg_data <= w_stg_data_nxt;
            if (w_drop || w_ds_err) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Burst beat counter and latched burst length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_cnt <= 4'd0;
            r_len_q    <= 4'd1;
        end else begin
            if (ds) begin
                r_beat_cnt <= 4'd0;
            end else if (rd && (r_beat_cnt != 4'hF)) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
            end
            if (rd && (r_beat_cnt == 4'd0)) begin
                r_len_q <= (burst_len == 4'd0) ? 4'd1 : burst_len;
            end
        end
    end

endmodule

// File: tb/tb_rd_capture_buf.sv
// tb/tb_rd_capture_buf.sv - self-checking bench for rd_capture_buf
module tb_rd_capture_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd = 1'b0;
    logic          ds = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic [3:0]    burst_len = 4'd1;
    logic          ws;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          ovf;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model
    logic [DW:0]   m_q[$];
    logic          m_stg;
    logic [DW-1:0] m_stg_d;
    logic          m_ovf;
    int            m_beats;
    int            m_len;
    logic [DW:0]   got[$];
    logic          ws_hist[16];
    int            n_rd;

    always #5 clk = ~clk;

    rd_capture_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rd(rd), .ds(ds), .mem_data(mem_data),
        .burst_len(burst_len), .ws(ws), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ws();
        return (m_beats < m_len) && ((DEPTH - m_q.size() - int'(m_stg)) >= 2);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_stg   = 1'b0;
        m_stg_d = '0;
        m_ovf   = 1'b0;
        m_beats = 0;
        m_len   = 1;
    endtask

    task automatic m_push(input logic [DW:0] w);
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    // One clock of the spec's rules, applied to the inputs present at the edge
    task automatic model_step();
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        if (rd) begin
            if (m_stg) m_push({1'b0, m_stg_d});
            if (ds) begin
                m_push({1'b1, mem_data});
                m_stg = 1'b0;
            end else begin
                m_stg   = 1'b1;
                m_stg_d = mem_data;
            end
        end else if (ds) begin
            if (m_stg) m_push({1'b1, m_stg_d});
            else m_ovf = 1'b1;
            m_stg = 1'b0;
        end
        if (rd && m_beats == 0) m_len = (burst_len == 0) ? 1 : int'(burst_len);
        if (ds) m_beats = 0;
        else if (rd && m_beats < 15) m_beats++;
    endtask

    // Compare process: checks every cycle at the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_ws", ws, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_ovf", ovf, 0);
        end else begin
            chk("out_valid", out_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("out_data", out_data, m_q[0][DW-1:0]);
                chk("out_last", out_last, m_q[0][DW]);
            end
            chk("ovf", ovf, m_ovf);
            chk("ws", ws, m_ws());
            if (out_valid && out_ready) got.push_back({out_last, out_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic idle(input int n);
        rd = 1'b0;
        ds = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_ws", ws, 0);
        chk("async_ovf", ovf, 0);
        rd = 1'b0;
        ds = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        got.delete();
    endtask

    // Upstream FSM: first rd, continue while ws=1, then close with ds
    task automatic run_burst(input logic [DW-1:0] base);
        n_rd = 0;
        rd = 1'b1;
        forever begin
            mem_data = base + DW'(n_rd);
            tick();
            ws_hist[n_rd] = ws;
            n_rd++;
            if (!ws || n_rd >= 16) break;
        end
        rd = 1'b0;
        ds = 1'b1;
        tick();
        ds = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        #1;
        chk("por_out_valid", out_valid, 0);
        chk("por_ws", ws, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("por_ovf", ovf, 0);
        idle(1);

        // two-word burst with downstream always ready
        out_ready = 1'b1;
        rd = 1'b1; mem_data = 8'hA1; tick();
        mem_data = 8'hA2; tick();
        rd = 1'b0; ds = 1'b1; tick();
        idle(3);
        chk("a_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("a_word0", got[0], 9'h0A1);
            chk("a_word1", got[1], 9'h1A2);
        end
        chk("a_ovf", ovf, 0);

        // burst_len=3 with the upstream loop closed through ws
        got.delete();
        burst_len = 4'd3;
        run_burst(8'hB1);
        idle(3);
        chk("b_rd_cnt", n_rd, 3);
        chk("b_ws1", ws_hist[0], 1);
        chk("b_ws2", ws_hist[1], 1);
        chk("b_ws3", ws_hist[2], 0);
        chk("b_count", got.size(), 3);
        if (got.size() == 3) chk("b_word2", got[2], 9'h1B3);

        // burst_len=8 with downstream stalled: ws throttles before anything drops
        got.delete();
        out_ready = 1'b0;
        burst_len = 4'd8;
        run_burst(8'h51);
        chk("c_rd_cnt", n_rd, 3);
        chk("c_ovf", ovf, 0);
        out_ready = 1'b1;
        idle(4);
        chk("c_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("c_word0", got[0], 9'h051);
            chk("c_word2", got[2], 9'h153);
        end

        // full FIFO: push in a pop cycle is accepted, push without pop drops
        got.delete();
        out_ready = 1'b0;
        rd = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            mem_data = 8'hC0 + 8'(i);
            tick();
        end
        out_ready = 1'b1; mem_data = 8'hC6; tick();
        chk("d_ovf_after_pop_push", ovf, 0);
        out_ready = 1'b0; mem_data = 8'hC7; tick();
        chk("d_ovf_after_drop", ovf, 1);
        out_ready = 1'b1; rd = 1'b0; ds = 1'b1; tick();
        idle(5);
        chk("d_count", got.size(), 6);
        if (got.size() == 6) begin
            chk("d_word4", got[4], 9'h0C5);
            chk("d_word5", got[5], 9'h1C7);
        end

        // rd and ds together with only one free slot: second word drops
        async_reset();
        idle(1);
        out_ready = 1'b0;
        rd = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mem_data = 8'hD0 + 8'(i);
            tick();
        end
        ds = 1'b1; mem_data = 8'hD5; tick();
        chk("e_ovf", ovf, 1);
        out_ready = 1'b1;
        idle(5);
        chk("e_count", got.size(), 4);
        if (got.size() == 4) chk("e_word3", got[3], 9'h0D4);

        // ds with nothing staged
        async_reset();
        idle(1);
        ds = 1'b1; tick();
        ds = 1'b0;
        chk("f_ovf", ovf, 1);
        chk("f_valid", out_valid, 0);

        // burst_len=0 behaves as one word
        async_reset();
        burst_len = 4'd0;
        rd = 1'b1; mem_data = 8'hE1; tick();
        chk("g_ws_len0", ws, 0);
        rd = 1'b0; ds = 1'b1; tick();
        idle(2);
        chk("g_count", got.size(), 1);
        if (got.size() == 1) chk("g_word0", got[0], 9'h1E1);

        // reset mid-burst with two words buffered
        async_reset();
        out_ready = 1'b0;
        burst_len = 4'd8;
        rd = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            mem_data = 8'hF0 + 8'(i);
            tick();
        end
        rd = 1'b0;
        chk("h_valid_before", out_valid, 1);
        async_reset();
        out_ready = 1'b1;
        idle(4);
        chk("h_count", got.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/rd_capture_buf.md
RD_CAPTURE_BUF -- requirements
Module: rd_capture_buf

Interface
REQ-001 Parameter DW, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 4, output FIFO depth in entries; power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low; rst=0 resets all state immediately.
REQ-005 rd  in  1  read strobe from the upstream read-sequencer FSM; mem_data is valid on every cycle rd=1.
REQ-006 ds  in  1  done strobe from the upstream FSM; one cycle; closes the current burst.
REQ-007 mem_data  in  DW  memory read data; sampled only when rd=1.
REQ-008 burst_len  in  4  requested words per burst; 0 is treated as 1; sampled on the first rd of each burst.
REQ-009 ws  out  1  continue request back to the upstream FSM; 1 means "issue another read".
REQ-010 out_valid  out  1  the FIFO head entry is valid.
REQ-011 out_ready  in  1  downstream accepts the head entry; a pop occurs on out_valid & out_ready.
REQ-012 out_data  out  DW  data field of the head entry.
REQ-013 out_last  out  1  last flag of the head entry; 1 marks the final word of a burst.
REQ-014 ovf  out  1  sticky error; set when a word is dropped or when ds arrives with no word staged.

Function
REQ-015 Stage register: 1-entry holding register {stg_vld, stg_data}; each rd=1 cycle loads mem_data and sets stg_vld=1.
REQ-016 Push without last: rd=1 with stg_vld=1 pushes the old stg_data to the FIFO with last=0 in the same cycle it loads the new word.
REQ-017 Push with last: ds=1 with stg_vld=1 pushes stg_data with last=1 and clears stg_vld.
REQ-018 If rd=1 and ds=1 in the same cycle, the old stage word is pushed with last=0, the new word is pushed with last=1, and stg_vld ends at 0. Two pushes are permitted only if the FIFO has at least 2 free slots after the same-cycle pop; otherwise the later word is dropped and ovf is set.
REQ-019 ds=1 with stg_vld=0 and rd=0: no push; set ovf.
REQ-020 FIFO: DEPTH entries of {last, data}. Pointers are log2(DEPTH)+1 bits and wrap naturally. full when the pointers differ only in the MSB; empty when the pointers are equal.
REQ-021 Capacity check: a push is accepted when count < DEPTH, or when count = DEPTH and a pop occurs in the same cycle. Otherwise the word is dropped, ovf is set, and FIFO contents are unchanged.
REQ-022 A pop when empty is impossible because out_valid=0; out_data and out_last are don't-care while out_valid=0.
REQ-023 Read path: out_valid = !empty; out_data and out_last are read combinationally from the head entry; zero-cycle latency from head to output.
REQ-024 Latency: a word sampled on rd at edge N becomes visible at the FIFO head no earlier than edge N+1 after its push, and is pushed no later than the ds edge.
REQ-025 Beat counter beat_cnt (4 bits): clears on ds; increments on each rd=1; saturates at 15.
REQ-026 len_q latches max(burst_len,1) on the rd that occurs when beat_cnt=0.
REQ-027 ws (combinational from registered state) = (beat_cnt < len_q) & (free_slots >= 2), where free_slots = DEPTH - count - stg_vld.
REQ-028 The upstream loop rd -> ws -> rd therefore yields exactly len_q reads per burst when space allows. When space is lacking, the burst ends early with ds and the remaining words are not requested.
REQ-029 ovf clears only on reset.

Reset
REQ-030 On rst=0: FIFO empty (both pointers 0), stg_vld=0, beat_cnt=0, len_q=1, ovf=0.
REQ-031 During reset: out_valid=0, ws=0, out_data=0, out_last=0.
REQ-032 A reset asserted mid-burst discards all staged and buffered words. No partial burst is emitted after reset release.

Verification
REQ-033 Sequence rd(0xA1), rd(0xA2), ds with out_ready=1 -> outputs {0xA1,last=0} then {0xA2,last=1}; ovf=0.
REQ-034 burst_len=3, DEPTH=4, out_ready=1, upstream FSM model in loop -> exactly 3 rd cycles; ws=1 after beats 1 and 2, ws=0 after beat 3; 3 words out, last on the third.
REQ-035 out_ready=0, burst_len=8 -> ws drops to 0 once free_slots<2; no word dropped; ovf=0; the FIFO drains correctly once out_ready=1.
REQ-036 FIFO full, forced push with out_ready=0 -> word dropped, ovf=1, contents unchanged; same push in a pop cycle -> accepted, ovf stays 0.
REQ-037 ds with no staged word -> no output, ovf=1. rst=0 mid-burst with 2 words buffered -> out_valid=0 asynchronously; all state at reset values.
